regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- Integer register file for the pipelined RISC-V core: 32 x 32-bit, two combinational read ports (rs1, rs2) and one synchronous write port.
- Sits in ID/WB. Reads feed the ID/EX pipeline register.
- The write address comes directly from the 5-bit write-register select mux in the writeback path, and the write data from the WB result mux.
- An internal write-to-read bypass lets an instruction in ID see the value being written back in the same cycle.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; must match the 5-bit select-mux output
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W
- BYPASS_EN, 1, 1 = same-cycle WB->read forwarding enabled; 0 = reads return stored value only

Ports:
- clk  input  1  core clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- rs1_addr  input  ADDR_W  read port 1 address
- rs2_addr  input  ADDR_W  read port 2 address
- rs1_data  output  DATA_W  read port 1 data, combinational
- rs2_data  output  DATA_W  read port 2 data, combinational
- wr_en  input  1  write enable from WB stage (RegWrite)
- wr_addr  input  ADDR_W  write address from the write-register select mux
- wr_data  input  DATA_W  write data from WB result mux
- dbg_addr  input  ADDR_W  debug/testbench peek address
- dbg_data  output  DATA_W  stored value at dbg_addr; combinational, never bypassed

Behaviour:
- Reset:
  - One clock, clk. Reset is asynchronous and active-low on rst_n.
  - While rst_n=0, all NUM_REGS entries clear to 0 immediately, independent of clk.
  - rs1_data, rs2_data and dbg_data therefore read 0 for any address during reset.
  - Writes are suppressed while rst_n=0.
- Write:
  - On posedge clk with rst_n=1, wr_en=1 and wr_addr!=0: regs[wr_addr] <= wr_data.
  - Write latency is 1 cycle to stored state.
  - wr_en=0 leaves all state unchanged.
- x0:
  - Register 0 is hardwired to zero. Writes to address 0 are dropped.
  - Any read of address 0 returns 0, including when wr_en=1 and wr_addr=0.
- Read:
  - rsN_data = (rsN_addr==0) ? 0 : bypass_hit ? wr_data : regs[rsN_addr].
  - bypass_hit = BYPASS_EN && wr_en && (wr_addr==rsN_addr) && (wr_addr!=0) && rst_n.
  - This gives write-before-read semantics: the result equals the value stored after the coming edge.
- Simultaneous events:
  - Both read ports may hit the bypass in the same cycle; each decides independently.
  - rs1_addr==rs2_addr gives identical data on both ports.
- Reset mid-operation:
  - Asserting rst_n low during a cycle with wr_en=1 discards that write; the register is 0 after reset.
  - Deassertion is synchronous-safe: the first write is accepted on the first posedge with rst_n=1.
- Width rules:
  - No sign handling; data is passed bit-exact.
  - Addresses are compared over the full ADDR_W bits.
- Assertion (sim only): flag wr_en with X on wr_addr or wr_data.

Decomposition:
- Shared package core_pkg:
  - XLEN=32, REG_ADDR_W=5, NUM_REGS=32
  - typedef reg_addr_t [4:0], typedef xdata_t [31:0]
  - constant REG_ZERO=5'd0
- One natural sub-module: regfile_rd_port, one instance per read port (rs1, rs2). It holds the zero check, bypass compare and array select, keeping both ports identical by construction.
- Storage and the write logic stay in the top module.

Test Plan:
- Reset clear: write 0xDEADBEEF to x5, pulse rst_n low mid-cycle -> rs1_data reads 0 at x5 immediately, and stays 0 after release until a new write.
- Basic write/read: wr_en=1, wr_addr=7, wr_data=0x12345678, posedge, then wr_en=0 with rs1_addr=rs2_addr=7 -> both ports return 0x12345678; dbg_addr=7 returns the same.
- x0 immutability: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF with rs1_addr=0 -> rs1_data=0 in that cycle and after the edge; dbg_data at 0 is 0.
- Bypass: x3 holds 0x11; in one cycle wr_en=1, wr_addr=3, wr_data=0x22, rs1_addr=3, rs2_addr=3 -> both ports show 0x22 before the edge, and dbg_data(3)=0x11 before / 0x22 after. With BYPASS_EN=0, both ports show 0x11 before the edge.
- Mixed ports: wr_addr=9 with wr_data=0xA5A5A5A5, rs1_addr=9, rs2_addr=10 holding 0x5 -> rs1_data=0xA5A5A5A5, rs2_data=0x5.
- Sweep: write the value addr*0x01010101 to x1..x31 on consecutive cycles, then read all via both ports -> every register matches, and x0=0.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared integer-core widths, types and constants
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xdata_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational register-file read port
module regfile_rd_port
  import core_pkg::*;
#(
  parameter int DATA_W    = XLEN,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int NUM_REGS  = core_pkg::NUM_REGS,
  parameter int BYPASS_EN = 1
) (
  input  logic                             rst_n,
  input  logic [ADDR_W-1:0]                rd_addr_i,
  input  logic                             wr_en_i,
  input  logic [ADDR_W-1:0]                wr_addr_i,
  input  logic [DATA_W-1:0]                wr_data_i,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_i,
  output logic [DATA_W-1:0]                rd_data_o
);

  logic addr_zero;
  logic bypass_hit;

  assign addr_zero  = (rd_addr_i == '0);
  // Write-before-read: an ID read of the register being written back sees the new value
  assign bypass_hit = (BYPASS_EN != 0) && wr_en_i && (wr_addr_i == rd_addr_i)
                      && (wr_addr_i != '0) && rst_n;

  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
    if (addr_zero) begin
      rd_data_o = '0;
    end else if (bypass_hit) begin
      rd_data_o = wr_data_i;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 32x32 integer register file, two read ports, one write port
module regfile_2r1w
  import core_pkg::*;
#(
  parameter int DATA_W    = XLEN,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int NUM_REGS  = core_pkg::NUM_REGS,
  parameter int BYPASS_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;

  // Entry 0 is never written, so it stays at its reset value of zero
  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != '0)) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_rd_port #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .NUM_REGS  (NUM_REGS),
    .BYPASS_EN (BYPASS_EN)
  ) u_rs1_port (
    .rst_n     (rst_n),
    .rd_addr_i (rs1_addr),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .regs_i    (regs_q),
    .rd_data_o (rs1_data)
  );

  regfile_rd_port #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .NUM_REGS  (NUM_REGS),
    .BYPASS_EN (BYPASS_EN)
  ) u_rs2_port (
    .rst_n     (rst_n),
    .rd_addr_i (rs2_addr),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .regs_i    (regs_q),
    .rd_data_o (rs2_data)
  );

  // Debug peek shows stored state only, never the in-flight write
  assign dbg_data = regs_q[dbg_addr];

  a_wr_known : assert property (@(posedge clk) disable iff (!rst_n)
    wr_en |-> !$isunknown({wr_addr, wr_data}));

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - scoreboard bench for regfile_2r1w with and without bypass
module tb_regfile_2r1w;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, dbg_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [31:0] rs1_data, rs2_data, dbg_data;
  logic [31:0] nb_rs1_data, nb_rs2_data, nb_dbg_data;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl[32];
  int          n_vec;
  int          n_err;

  regfile_2r1w #(.BYPASS_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  regfile_2r1w #(.BYPASS_EN(0)) u_dut_nobyp (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] port_val(input int port);
    case (port)
      0:       return rs1_data;
      1:       return rs2_data;
      2:       return dbg_data;
      3:       return nb_rs1_data;
      4:       return nb_rs2_data;
      default: return nb_dbg_data;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int port, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Let combinational outputs settle, then compare everything queued
  task automatic drain();
    exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, port_val(e.port), e.exp);
    end
  endtask

  task automatic tick();
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    w = rst_n && wr_en && (wr_addr != 5'd0);
    a = wr_addr;
    d = wr_data;
    @(posedge clk);
    if (w) mdl[a] = d;
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    wr_en   = en;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic set_rd(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    rs1_addr = a1;
    rs2_addr = a2;
    dbg_addr = ad;
  endtask

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (rst_n && wr_en && (wr_addr == a)) return wr_data;
    return mdl[a];
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    rst_n = 1'b0;
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd5, 5'd31, 5'd5);
    #12;
    expect_val("rst_rs1", 0, 32'h0);
    expect_val("rst_rs2", 1, 32'h0);
    expect_val("rst_dbg", 2, 32'h0);
    drain();
    rst_n = 1'b1;
    tick();

    // Reset clear, asserted mid-cycle with a write pending
    set_wr(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    set_wr(1'b0, 5'd5, 32'h0);
    expect_val("x5_written", 0, 32'hDEADBEEF);
    drain();
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    set_wr(1'b1, 5'd5, 32'hCAFEF00D);
    expect_val("async_rst_rs1", 0, 32'h0);
    expect_val("async_rst_dbg", 2, 32'h0);
    drain();
    tick();
    expect_val("rst_write_dropped", 0, 32'h0);
    drain();
    #2;
    rst_n = 1'b1;
    set_wr(1'b0, 5'd5, 32'h0);
    tick();
    expect_val("post_rst_still0", 0, 32'h0);
    drain();
    set_wr(1'b1, 5'd5, 32'h00001234);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    expect_val("first_write_after_rst", 0, 32'h00001234);
    drain();

    // Basic write/read on both ports and debug
    set_wr(1'b1, 5'd7, 32'h12345678);
    tick();
    set_wr(1'b0, 5'd7, 32'h0);
    set_rd(5'd7, 5'd7, 5'd7);
    expect_val("basic_rs1", 0, 32'h12345678);
    expect_val("basic_rs2", 1, 32'h12345678);
    expect_val("basic_dbg", 2, 32'h12345678);
    drain();

    // x0 stays zero even with a write aimed at it
    set_wr(1'b1, 5'd0, 32'hFFFFFFFF);
    set_rd(5'd0, 5'd0, 5'd0);
    expect_val("x0_rs1_same", 0, 32'h0);
    expect_val("x0_rs2_same", 1, 32'h0);
    drain();
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    expect_val("x0_rs1_after", 0, 32'h0);
    expect_val("x0_dbg_after", 2, 32'h0);
    drain();

    // Bypass versus stored-only reads
    set_wr(1'b1, 5'd3, 32'h11);
    tick();
    set_wr(1'b1, 5'd3, 32'h22);
    set_rd(5'd3, 5'd3, 5'd3);
    expect_val("byp_rs1", 0, 32'h22);
    expect_val("byp_rs2", 1, 32'h22);
    expect_val("byp_dbg_before", 2, 32'h11);
    expect_val("nobyp_rs1", 3, 32'h11);
    expect_val("nobyp_rs2", 4, 32'h11);
    expect_val("nobyp_dbg", 5, 32'h11);
    drain();
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    expect_val("byp_dbg_after", 2, 32'h22);
    expect_val("nobyp_rs1_after", 3, 32'h22);
    drain();

    // One port bypassed, the other reading stored state
    set_wr(1'b1, 5'd10, 32'h5);
    tick();
    set_wr(1'b1, 5'd9, 32'hA5A5A5A5);
    set_rd(5'd9, 5'd10, 5'd9);
    expect_val("mixed_rs1", 0, 32'hA5A5A5A5);
    expect_val("mixed_rs2", 1, 32'h5);
    expect_val("mixed_dbg", 2, 32'h0);
    expect_val("mixed_nobyp_rs1", 3, 32'h0);
    drain();
    tick();

    // Sweep every register then read back through both ports
    for (int a = 1; a < 32; a++) begin
      set_wr(1'b1, 5'(a), 32'(a) * 32'h01010101);
      tick();
    end
    set_wr(1'b0, 5'd0, 32'h0);
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a), 5'(a));
      expect_val($sformatf("sweep_rs1_x%0d", a), 0, (a == 0) ? 32'h0 : 32'(a) * 32'h01010101);
      expect_val($sformatf("sweep_rs2_x%0d", 31 - a), 1,
                 (a == 31) ? 32'h0 : 32'(31 - a) * 32'h01010101);
      drain();
    end

    // Random traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      set_wr(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      set_rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (i % 4 == 0) rs2_addr = wr_addr;
      expect_val("rand_rs1", 0, ref_rd(rs1_addr));
      expect_val("rand_rs2", 1, ref_rd(rs2_addr));
      expect_val("rand_dbg", 2, mdl[dbg_addr]);
      expect_val("rand_nobyp_rs2", 4, mdl[rs2_addr]);
      drain();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
